// File: rtl/bram_sdp_rr_arbiter_if.sv
// Client-side and BRAM-side signal bundle for bram_sdp_rr_arbiter.
// The arbiter takes the slave modport; the client/BRAM side takes master.
interface bram_sdp_rr_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 36
);
  logic [1:0]            rd_req_i;
  logic [ADDR_WIDTH-1:0] rd_addr0_i;
  logic [ADDR_WIDTH-1:0] rd_addr1_i;
  logic [1:0]            rd_gnt_o;
  logic [1:0]            rd_valid_o;
  logic [DATA_WIDTH-1:0] rd_data_o;

  logic [1:0]            wr_req_i;
  logic [ADDR_WIDTH-1:0] wr_addr0_i;
  logic [ADDR_WIDTH-1:0] wr_addr1_i;
  logic [DATA_WIDTH-1:0] wr_data0_i;
  logic [DATA_WIDTH-1:0] wr_data1_i;
  logic [1:0]            wr_gnt_o;

  logic                  REN_o;
  logic [ADDR_WIDTH-1:0] RD_ADDR_o;
  logic [DATA_WIDTH-1:0] RDATA_i;
  logic                  WEN_o;
  logic [ADDR_WIDTH-1:0] WR_ADDR_o;
  logic [DATA_WIDTH-1:0] WDATA_o;

  modport slave (
    input  rd_req_i, rd_addr0_i, rd_addr1_i,
    input  wr_req_i, wr_addr0_i, wr_addr1_i, wr_data0_i, wr_data1_i,
    input  RDATA_i,
    output rd_gnt_o, rd_valid_o, rd_data_o, wr_gnt_o,
    output REN_o, RD_ADDR_o, WEN_o, WR_ADDR_o, WDATA_o
  );

  modport master (
    output rd_req_i, rd_addr0_i, rd_addr1_i,
    output wr_req_i, wr_addr0_i, wr_addr1_i, wr_data0_i, wr_data1_i,
    output RDATA_i,
    input  rd_gnt_o, rd_valid_o, rd_data_o, wr_gnt_o,
    input  REN_o, RD_ADDR_o, WEN_o, WR_ADDR_o, WDATA_o
  );
endinterface

// File: rtl/bram_sdp_rr_arbiter.sv
// Two-requester round-robin arbiter sharing one simple-dual-port BRAM; read and write ports arbitrated independently.
// Optional write-first read-after-write bypass: define BRAM_ARB_RAW_BYPASS_EN.
module bram_sdp_rr_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 36
) (
  input logic                   clk,
  input logic                   rst,
  bram_sdp_rr_arbiter_if.slave  bus
);

  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_valid_q, rd_valid_d;
  logic [1:0] rd_gnt, wr_gnt;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // Lone requester wins; on contention the pointer picks the winner.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
    logic [1:0] gnt;
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

  always_comb begin
    rd_gnt     = 2'b00;
    wr_gnt     = 2'b00;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_addr    = bus.rd_addr0_i;
    wr_addr    = bus.wr_addr0_i;
    wr_data    = bus.wr_data0_i;
    rd_valid_d = 2'b00;
    if (!rst) begin
      rd_gnt = rr_pick(bus.rd_req_i, rd_ptr_q);
      wr_gnt = rr_pick(bus.wr_req_i, wr_ptr_q);
    end
    // Pointer moves to the requester that just lost its turn.
    if (rd_gnt[1])      rd_ptr_d = 1'b0;
    else if (rd_gnt[0]) rd_ptr_d = 1'b1;
    if (wr_gnt[1])      wr_ptr_d = 1'b0;
    else if (wr_gnt[0]) wr_ptr_d = 1'b1;
    if (rd_gnt[1]) rd_addr = bus.rd_addr1_i;
    if (wr_gnt[1]) begin
      wr_addr = bus.wr_addr1_i;
      wr_data = bus.wr_data1_i;
    end
    rd_valid_d = rd_gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_valid_q <= 2'b00;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_gnt_o   = rd_gnt;
  assign bus.wr_gnt_o   = wr_gnt;
  assign bus.REN_o      = |rd_gnt;
  assign bus.RD_ADDR_o  = rd_addr;
  assign bus.WEN_o      = |wr_gnt;
  assign bus.WR_ADDR_o  = wr_addr;
  assign bus.WDATA_o    = wr_data;
  // A valid still in flight when reset arrives is dropped.
  assign bus.rd_valid_o = rd_valid_q & {2{~rst}};

`ifdef BRAM_ARB_RAW_BYPASS_EN
  logic                  hit_q, hit_d;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;

  // Same-address read and write in one cycle returns the new write data.
  always_comb begin
    hit_d      = (|rd_gnt) && (|wr_gnt) && (rd_addr == wr_addr);
    byp_data_d = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      hit_q      <= hit_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign bus.rd_data_o = hit_q ? byp_data_q : bus.RDATA_i;
`else
  assign bus.rd_data_o = bus.RDATA_i;
`endif

endmodule

// File: doc/bram_sdp_rr_arbiter.md
Name: bram_sdp_rr_arbiter

Overview:
- Shares one simple-dual-port BRAM (spram_36x1024-class: REN/RD_ADDR/RDATA read port, WEN/WR_ADDR/WDATA write port, one clock) between two requesters.
- The read port and the write port are arbitrated independently, each with its own round-robin pointer.
- Read data returns with fixed 1-cycle latency and is tagged with the granted requester.
- Sits between the two client datapaths and the BRAM instance in the qlf_k6n10f BRAM test designs.

Parameters:
- ADDR_WIDTH, 10, BRAM address width.
- DATA_WIDTH, 36, BRAM data width; legal values 36, 32, 18, 16, 9, 8.

Ports:
- clk  in  1  single clock; also drives the BRAM clock0/clock1.
- rst  in  1  synchronous, active-high reset.
- rd_req_i  in  2  per-requester read request.
- rd_addr0_i, rd_addr1_i  in  ADDR_WIDTH  read address of requester 0 / 1.
- rd_gnt_o  out  2  one-hot read grant, combinational, same cycle as the request.
- rd_valid_o  out  2  one-hot: read data valid for that requester.
- rd_data_o  out  DATA_WIDTH  read data, shared by both requesters.
- wr_req_i  in  2  per-requester write request.
- wr_addr0_i, wr_addr1_i  in  ADDR_WIDTH  write address of requester 0 / 1.
- wr_data0_i, wr_data1_i  in  DATA_WIDTH  write data of requester 0 / 1.
- wr_gnt_o  out  2  one-hot write grant, combinational.
- REN_o, RD_ADDR_o  out  1, ADDR_WIDTH  to BRAM read port.
- RDATA_i  in  DATA_WIDTH  from BRAM, valid the cycle after REN is sampled.
- WEN_o, WR_ADDR_o, WDATA_o  out  1, ADDR_WIDTH, DATA_WIDTH  to BRAM write port.

Behaviour:
- Reset: rd_ptr = 0 and wr_ptr = 0 (requester 0 preferred); rd_valid_o = 0; tag and bypass registers cleared.
  - While rst is high, rd_gnt_o, wr_gnt_o, REN_o and WEN_o are forced to 0.
- Read arbitration, per cycle:
  - Only one requester active: grant it.
  - Both active: grant requester rd_ptr.
  - On any grant, rd_ptr <= ~granted index at the posedge.
  - No request: rd_ptr holds.
- Request handling:
  - A request is consumed only in a cycle where its grant is high.
  - An ungranted requester keeps req and addr stable until granted.
  - Worst-case wait is 1 cycle.
- Read path:
  - REN_o = |rd_gnt_o; RD_ADDR_o = granted address.
  - When no read is granted, RD_ADDR_o = rd_addr0_i (don't-care).
  - Latency: grant in cycle N → rd_valid_o[k] high for exactly cycle N+1, with rd_data_o = RDATA_i.
  - rd_valid_o is registered from rd_gnt_o; back-to-back grants give back-to-back valids.
- Write path:
  - Same round-robin rule using wr_ptr.
  - WEN_o = |wr_gnt_o; WR_ADDR_o and WDATA_o are muxed from the granted requester.
  - Write takes effect at the posedge ending cycle N.
- Independence: read and write grants in the same cycle are independent; both ports may be used every cycle by different or the same requesters.
- Same-address read/write in one cycle (feature disabled): rd_data_o returns whatever the BRAM produces (old data); the arbiter does not alter it.
- Reset mid-operation:
  - A grant issued in the cycle rst rises produces no rd_valid_o.
  - Any pending valid is dropped.
  - Pointers return to 0 on the next edge.
- No combinational path from RDATA_i to any grant output.

Optional Feature:
- Macro: BRAM_ARB_RAW_BYPASS_EN.
- Defined:
  - When a read grant and a write grant in cycle N target the same address, the granted write data is registered along with a hit flag.
  - In cycle N+1, rd_data_o returns the registered write data instead of RDATA_i (write-first semantics).
  - The hit flag is cleared by rst.
- Undefined: no compare logic or bypass registers; rd_data_o = RDATA_i always.

Test Plan:
- Reset, then req0 reads addr 0x005 after a write of 0x155005 to addr 0x005 → rd_gnt_o = 01 same cycle; rd_valid_o = 01 and rd_data_o = 0x155005 the next cycle.
- Both requesters hold read requests for 4 cycles (addr 0x001 / 0x002) → grants 01, 10, 01, 10; valids follow one cycle later with matching data.
- Both requesters hold write requests (0x010 ← 0xA, 0x011 ← 0xB), then read back both → both memory locations hold the written values; each grant lasts exactly 1 cycle.
- Read 0x020 and write 0x020 ← 0x3 in the same cycle, old content 0x7 → macro undefined: rd_data_o = 0x7; macro defined: rd_data_o = 0x3.
- Assert rst in the cycle a read is granted → rd_valid_o stays 0; the next contending read is granted to requester 0.
- Full sweep over 1024 addresses with alternating requesters writing a | (a<<20) | 0x55000, then reading back → zero mismatches.
